// File: rtl/fp_add_sub_top.sv
// Purpose: IEEE-754 binary32 adder/subtractor, round to nearest even, subnormals flushed to zero.
// Latency: 1 cycle, combinational datapath into one output register; one new operation every cycle.
// Backpressure: none; no handshake, every rising clk edge captures the current operands.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears result to +0
//   add_or_sub 0 = operand_1 + operand_2, 1 = operand_1 - operand_2
//   operand_1  binary32 input A
//   operand_2  binary32 input B
//   result     registered binary32 sum or difference
module fp_add_sub_top (
    input  logic        clk,
    input  logic        rst,
    input  logic        add_or_sub,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    output logic [31:0] result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Leading-zero count of the 27-bit normalisation window (hidden bit at 26).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Unpacked operands; B carries the effective sign after subtract inversion.
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

    always_comb begin
        sign_a = operand_1[31];
        exp_a  = operand_1[30:23];
        frac_a = operand_1[22:0];
        sign_b = operand_2[31] ^ add_or_sub;
        exp_b  = operand_2[30:23];
        frac_b = operand_2[22:0];
        // Exponent 0 covers both true zero and subnormals, which are flushed.
        zero_a = (exp_a == 8'd0);
        zero_b = (exp_b == 8'd0);
        inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
        inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
        nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
        nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    end

    // Magnitude ordering and alignment.
    logic        a_is_big;
    logic        sign_big;
    logic [7:0]  exp_big, exp_small, exp_diff;
    logic [4:0]  shamt;
    logic [27:0] sig_big, sig_small, sig_shift, sticky_mask, sig_aligned;
    logic        eff_sub;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [26:0] norm;
    logic [9:0]  exp_norm, exp_fin;
    logic [24:0] mant;
    logic [22:0] frac_fin;
    logic [31:0] res_comb;

    always_comb begin
        // Compare exponent then fraction as one 31-bit magnitude.
        a_is_big  = ({exp_a, frac_a} >= {exp_b, frac_b});
        sign_big  = a_is_big ? sign_a : sign_b;
        exp_big   = a_is_big ? exp_a : exp_b;
        exp_small = a_is_big ? exp_b : exp_a;
        // Working field: [27] carry headroom, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
        sig_big   = a_is_big ? {2'b01, frac_a, 3'b000} : {2'b01, frac_b, 3'b000};
        sig_small = a_is_big ? {2'b01, frac_b, 3'b000} : {2'b01, frac_a, 3'b000};
        exp_diff  = exp_big - exp_small;
        // A shift of 27 already moves the hidden bit fully into sticky, so larger ones are equivalent.
        shamt       = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        sticky_mask = (28'd1 << shamt) - 28'd1;
        sig_shift   = sig_small >> shamt;
        sig_aligned = {sig_shift[27:1], sig_shift[0] | (|(sig_small & sticky_mask))};

        eff_sub = sign_a ^ sign_b;
        sum     = eff_sub ? (sig_big - sig_aligned) : (sig_big + sig_aligned);

        lz = lzc27(sum[26:0]);
        if (sum[27]) begin
            // Carry out: drop one bit into sticky and bump the exponent.
            norm     = {sum[27:2], sum[1] | sum[0]};
            exp_norm = {2'b00, exp_big} + 10'd1;
        end else begin
            norm     = sum[26:0] << lz;
            exp_norm = {2'b00, exp_big} - {5'd0, lz};
        end

        // RNE: round up when guard is set and any of round, sticky or the LSB is set.
        mant = {1'b0, norm[26:3]} + {24'd0, norm[2] & (norm[1] | norm[0] | norm[3])};
        if (mant[24]) begin
            frac_fin = mant[23:1];
            exp_fin  = exp_norm + 10'd1;
        end else begin
            frac_fin = mant[22:0];
            exp_fin  = exp_norm;
        end

        // Bit 9 of exp_fin flags a negative (wrapped) exponent.
        if (sum == 28'd0 || exp_fin[9] || exp_fin == 10'd0) begin
            res_comb = 32'h0000_0000;
        end else if (exp_fin >= 10'd255) begin
            res_comb = {sign_big, 8'hFF, 23'd0};
        end else begin
            res_comb = {sign_big, exp_fin[7:0], frac_fin};
        end

        // Special operands override the datapath.
        if (nan_a || nan_b) begin
            res_comb = QNAN;
        end else if (inf_a && inf_b) begin
            res_comb = eff_sub ? QNAN : {sign_a, 8'hFF, 23'd0};
        end else if (inf_a) begin
            res_comb = {sign_a, 8'hFF, 23'd0};
        end else if (inf_b) begin
            res_comb = {sign_b, 8'hFF, 23'd0};
        end else if (zero_a && zero_b) begin
            res_comb = 32'h0000_0000;
        end else if (zero_b) begin
            res_comb = operand_1;
        end else if (zero_a) begin
            // Zero minus x yields -x, so B is returned with its effective sign.
            res_comb = {sign_b, exp_b, frac_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) result <= 32'h0000_0000;
        else     result <= res_comb;
    end

endmodule

// File: tb/tb_fp_add_sub_top.sv
module tb_fp_add_sub_top;

    logic        clk;
    logic        rst;
    logic        add_or_sub;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    fp_add_sub_top dut (
        .clk        (clk),
        .rst        (rst),
        .add_or_sub (add_or_sub),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic run(input string tag, input logic op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        add_or_sub = op;
        operand_1  = a;
        operand_2  = b;
        @(posedge clk);
        #1;
        check(tag, result, exp);
    endtask

    initial begin
        rst        = 1'b1;
        add_or_sub = 1'b0;
        operand_1  = 32'h4040_0000;
        operand_2  = 32'h4040_0000;
        #2;
        check("reset_state", result, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_held_edge", result, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        // Basic arithmetic
        run("add_5_3",       1'b0, 32'h40A0_0000, 32'h4040_0000, 32'h4100_0000);
        run("sub_10_2p5",    1'b1, 32'h4120_0000, 32'h4020_0000, 32'h40F0_0000);
        run("sub_3_5",       1'b1, 32'h4040_0000, 32'h40A0_0000, 32'hC000_0000);
        // Cancellation and overflow
        run("cancel",        1'b0, 32'h4120_0000, 32'hC120_0000, 32'h0000_0000);
        run("x_minus_x",     1'b1, 32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000);
        run("zero_minus_0",  1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        run("overflow",      1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        run("ovf_round",     1'b0, 32'h7F7F_FFFF, 32'h7300_0000, 32'h7F80_0000);
        // Rounding
        run("tie_even",      1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        run("tie_odd_up",    1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        run("sticky_only",   1'b0, 32'h3F80_0000, 32'h3000_0001, 32'h3F80_0000);
        // 1.0 - 2^-25: exact result 1 - 2^-25 rounds back to 1.0
        run("sub_round",     1'b1, 32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000);
        // Specials
        run("inf_plus_inf",  1'b0, 32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000);
        run("inf_minus_inf", 1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
        run("ninf_sub_inf",  1'b1, 32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000);
        run("inf_plus_fin",  1'b0, 32'h4040_0000, 32'hFF80_0000, 32'hFF80_0000);
        run("nan_in",        1'b0, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
        run("max_plus_sub",  1'b0, 32'h7F7F_FFFF, 32'h0000_0001, 32'h7F7F_FFFF);
        run("x_plus_zero",   1'b0, 32'h40A0_0000, 32'h0000_0000, 32'h40A0_0000);
        run("zero_minus_x",  1'b1, 32'h0000_0000, 32'h40A0_0000, 32'hC0A0_0000);
        run("subn_flush",    1'b0, 32'h0040_0000, 32'h0040_0000, 32'h0000_0000);
        run("underflow",     1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000);

        // Reset mid-stream: asynchronous clear, no stale value after release.
        @(negedge clk);
        operand_1 = 32'h4120_0000;
        operand_2 = 32'h4120_0000;
        add_or_sub = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_val", result, 32'h41A0_0000);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", result, 32'h0000_0000);
        @(negedge clk);
        rst        = 1'b0;
        operand_1  = 32'h3FC0_0000;
        operand_2  = 32'h3FC0_0000;
        #1;
        check("no_stale", result, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("post_reset", result, 32'h4040_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
